// File: rtl/mips_run_monitor.sv
// -----------------------------------------------------------------------------
// mips_run_monitor
//
// Run monitor for the single-cycle MIPS core. It watches the core's PC and
// register-file write port while a run is active and keeps a shadow copy of
// the register file. A run ends in one of two ways:
//   - halt: the PC has been unchanged for HALT_REPEAT consecutive cycles.
//   - timeout: the cycle budget MAX_CYCLES is used up.
// The monitor then streams the final PC and every shadow register out over a
// valid/ready port.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a run (from IDLE or DONE)
//   pc                core program counter
//   reg_we/waddr/wdata core register-file write port (snooped)
//   dump_valid/ready  dump stream handshake
//   dump_is_pc        current beat carries the final PC
//   dump_index        register index of the current beat (0 on the PC beat)
//   dump_data         beat payload
//   busy              high in RUN and DUMP
//   done              dump complete, results held
//   timeout           last run ended by budget rather than by halt
//   cycle_count       RUN cycles of the current/last run
// -----------------------------------------------------------------------------
module mips_run_monitor #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int NUM_REGS    = 32,
    parameter int MAX_CYCLES  = 4096,
    parameter int HALT_REPEAT = 3,
    localparam int CYC_W      = $clog2(MAX_CYCLES + 1),
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W-1:0]   pc,
    input  logic              reg_we,
    input  logic [4:0]        reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_is_pc,
    output logic [IDX_W-1:0]  dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int SAME_W = $clog2(HALT_REPEAT + 1);
    localparam int BEAT_W = $clog2(NUM_REGS + 1);

    localparam logic [SAME_W:0]   HALT_TGT  = (SAME_W + 1)'(HALT_REPEAT);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [PC_W-1:0]   prev_pc;
    logic              have_prev;
    logic [SAME_W-1:0] same_cnt;
    logic [BEAT_W-1:0] beat;

    logic wr_hit;
    logic pc_same;
    logic halt_hit;
    logic budget_hit;

    // PC is zero-extended or truncated to the payload width.
    function automatic logic [DATA_W-1:0] fit_pc(input logic [PC_W-1:0] p);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < PC_W) r[i] = p[i];
        end
        return r;
    endfunction

    always_comb begin
        wr_hit     = 1'b0;
        pc_same    = 1'b0;
        halt_hit   = 1'b0;
        budget_hit = 1'b0;

        // Register 0 is hard-wired zero; addresses beyond the shadow are dropped.
        wr_hit = reg_we && (reg_waddr != 5'd0) && (32'(reg_waddr) < NUM_REGS);

        // The first RUN cycle has no previous PC to compare against.
        pc_same = have_prev && (pc == prev_pc);

        // Halt fires on the cycle whose comparison brings the run of equal PCs
        // up to HALT_REPEAT.
        halt_hit = pc_same && (({1'b0, same_cnt} + 1'b1) == HALT_TGT);

        // This cycle's increment brings cycle_count to MAX_CYCLES.
        budget_hit = (cycle_count == LAST_CYC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prev_pc     <= '0;
            have_prev   <= 1'b0;
            same_cnt    <= '0;
            beat        <= '0;
            dump_valid  <= 1'b0;
            dump_is_pc  <= 1'b0;
            dump_index  <= '0;
            dump_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        same_cnt    <= '0;
                        have_prev   <= 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
                    end
                end

                S_RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    prev_pc     <= pc;
                    have_prev   <= 1'b1;
                    same_cnt    <= pc_same ? same_cnt + 1'b1 : '0;

                    // Writes in the final RUN cycle are still captured.
                    if (wr_hit) shadow[reg_waddr[IDX_W-1:0]] <= reg_wdata;

                    if (halt_hit || budget_hit) begin
                        state      <= S_DUMP;
                        timeout    <= !halt_hit;
                        beat       <= '0;
                        dump_valid <= 1'b1;
                        dump_is_pc <= 1'b1;
                        dump_index <= '0;
                        dump_data  <= fit_pc(pc);
                    end
                end

                S_DUMP: begin
                    // dump_valid is always high here; a beat moves only on ready,
                    // so the presented beat is held unchanged through stalls.
                    if (dump_ready) begin
                        if (beat == LAST_BEAT) begin
                            state      <= S_DONE;
                            dump_valid <= 1'b0;
                            dump_is_pc <= 1'b0;
                            dump_index <= '0;
                            dump_data  <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            // Beat k (k>=1) carries shadow[k-1]; beat holds k-1.
                            beat       <= beat + 1'b1;
                            dump_is_pc <= 1'b0;
                            dump_index <= beat[IDX_W-1:0];
                            dump_data  <= shadow[beat[IDX_W-1:0]];
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
module tb_mips_run_monitor;

    localparam int DATA_W      = 32;
    localparam int PC_W        = 32;
    localparam int NUM_REGS    = 32;
    localparam int MAX_CYCLES  = 16;
    localparam int HALT_REPEAT = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pc;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_is_pc;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [4:0]  cycle_count;

    mips_run_monitor #(
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .NUM_REGS    (NUM_REGS),
        .MAX_CYCLES  (MAX_CYCLES),
        .HALT_REPEAT (HALT_REPEAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc          (pc),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_is_pc  (dump_is_pc),
        .dump_index  (dump_index),
        .dump_data   (dump_data),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run scenario: how the PC moves, how writes are made, how the
    // consumer behaves, and what the run must end with.
    typedef struct {
        int          n_move;   // PC steps by 4 for this many cycles, then sticks
        int          wr_mode;  // 0 none, 1 directed list, 2 random every cycle
        int          rdy_mode; // 0 always ready, 1 random, 2 never ready
        int          exp_cyc;
        bit          exp_to;
        logic [31:0] exp_pc;
    } run_vec_t;

    typedef struct {
        bit          is_pc;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    run_vec_t    vecs [5];
    beat_t       sbq [$];
    logic [31:0] exp_shadow [NUM_REGS];

    int passed = 0;
    int total  = 0;
    int ready_mode = 0;

    bit          stall_seen = 1'b0;
    logic [38:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Consumer ready driver.
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = 1'b0;
            endcase
        end
    end

    // Dump monitor: pops the scoreboard on every transfer and checks that a
    // stalled beat is still presented unchanged one cycle later.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen)
                check("stall_hold", 64'({dump_valid, dump_is_pc, dump_index, dump_data}), 64'(held));
            if (dump_valid && dump_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL extra_beat: got transfer idx %0d data %0h, required no transfer",
                             dump_index, dump_data);
                end else begin
                    e = sbq.pop_front();
                    check("beat", 64'({dump_is_pc, dump_index, dump_data}),
                          64'({e.is_pc, e.idx, e.data}));
                end
                stall_seen = 1'b0;
            end else if (dump_valid) begin
                stall_seen = 1'b1;
                held = {dump_valid, dump_is_pc, dump_index, dump_data};
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic run_one(input run_vec_t v);
        int k;
        ready_mode = v.rdy_mode;
        @(posedge clk);
        #1;
        start  = 1'b1;
        pc     = 32'h0;
        reg_we = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("run_busy", 64'(busy), 64'd1);
        check("run_cyc0", 64'(cycle_count), 64'd0);
        check("run_done0", 64'(done), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) exp_shadow[i] = 32'h0;

        for (int c = 1; c <= v.exp_cyc; c++) begin
            pc    = (c <= v.n_move) ? 32'((c - 1) * 4) : 32'((v.n_move - 1) * 4);
            start = (v.wr_mode == 2 && c == 2);
            case (v.wr_mode)
                1: begin
                    reg_we    = 1'b1;
                    reg_wdata = $urandom;
                    reg_waddr = 5'($urandom_range(1, 31));
                    case (c)
                        1:       begin reg_waddr = 5'd8;  reg_wdata = 32'h0000_0005; end
                        2:       begin reg_waddr = 5'd0;  reg_wdata = 32'hFFFF_FFFF; end
                        3:       begin reg_waddr = 5'd31; reg_wdata = 32'hDEAD_BEEF; end
                        4:       begin reg_waddr = 5'd8;  reg_wdata = 32'h0000_000A; end
                        default: reg_we = 1'b0;
                    endcase
                end
                2: begin
                    reg_we    = 1'($urandom_range(0, 1));
                    reg_waddr = 5'($urandom_range(0, 31));
                    reg_wdata = $urandom;
                    if (c == v.exp_cyc) begin
                        reg_we    = 1'b1;
                        reg_waddr = 5'($urandom_range(1, 31));
                    end
                end
                default: reg_we = 1'b0;
            endcase
            if (reg_we && reg_waddr != 5'd0) exp_shadow[reg_waddr] = reg_wdata;
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // Writes during the dump must not reach the shadow file.
        reg_we    = 1'b1;
        reg_waddr = 5'd5;
        reg_wdata = 32'h1234_5678;

        check("end_cycle_count", 64'(cycle_count), 64'(v.exp_cyc));
        check("end_timeout", 64'(timeout), 64'(v.exp_to));
        check("dump_busy", 64'(busy), 64'd1);
        check("dump_valid_first", 64'(dump_valid), 64'd1);
        sbq.push_back('{1'b1, 5'd0, v.exp_pc});
        for (int i = 0; i < NUM_REGS; i++) sbq.push_back('{1'b0, 5'(i), exp_shadow[i]});

        for (k = 0; k < 400 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        reg_we = 1'b0;
        check("done_reached", 64'(done), 64'd1);
        if (v.rdy_mode == 0) check("zero_stall_len", 64'(k), 64'(NUM_REGS + 1));
        check("done_not_busy", 64'(busy), 64'd0);
        check("all_beats", 64'(sbq.size()), 64'd0);
        check("held_cycle_count", 64'(cycle_count), 64'(v.exp_cyc));
        check("held_timeout", 64'(timeout), 64'(v.exp_to));
    endtask

    initial begin
        vecs[0] = '{n_move: 4,   wr_mode: 1, rdy_mode: 0, exp_cyc: 7,  exp_to: 1'b0, exp_pc: 32'h0000_000C};
        vecs[1] = '{n_move: 100, wr_mode: 2, rdy_mode: 1, exp_cyc: 16, exp_to: 1'b1, exp_pc: 32'h0000_003C};
        vecs[2] = '{n_move: 1,   wr_mode: 0, rdy_mode: 0, exp_cyc: 4,  exp_to: 1'b0, exp_pc: 32'h0000_0000};
        vecs[3] = '{n_move: 13,  wr_mode: 2, rdy_mode: 0, exp_cyc: 16, exp_to: 1'b0, exp_pc: 32'h0000_0030};
        vecs[4] = '{n_move: 14,  wr_mode: 2, rdy_mode: 1, exp_cyc: 16, exp_to: 1'b1, exp_pc: 32'h0000_0034};

        rst_n     = 1'b0;
        start     = 1'b0;
        pc        = 32'h0;
        reg_we    = 1'b0;
        reg_waddr = 5'd0;
        reg_wdata = 32'h0;
        #1;
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_beat", 64'({dump_is_pc, dump_index, dump_data}), 64'd0);
        check("rst_flags", 64'({busy, done, timeout}), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Halt, directed shadowing, timeout under backpressure, then a re-run
        // from DONE with no writes.
        for (int r = 0; r < 3; r++) run_one(vecs[r]);

        // Reset in the middle of a stalled dump.
        ready_mode = 2;
        @(posedge clk);
        #1;
        start = 1'b1;
        pc    = 32'h0000_0040;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_dump_valid", 64'(dump_valid), 64'd1);
        check("mid_dump_pc_beat", 64'({dump_is_pc, dump_data}), 64'({1'b1, 32'h0000_0040}));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_ignored_dump", 64'({busy, dump_valid, dump_is_pc}), 64'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(dump_valid), 64'd0);
        check("async_rst_beat", 64'({dump_is_pc, dump_index, dump_data}), 64'd0);
        check("async_rst_flags", 64'({busy, done, timeout}), 64'd0);
        check("async_rst_cyc", 64'(cycle_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 64'({busy, done, dump_valid}), 64'd0);

        // Halt and timeout on the same cycle, then timeout one cycle short of halt.
        for (int r = 3; r < 5; r++) run_one(vecs[r]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish by 200000, required finish");
        $fatal(1);
    end

endmodule
